// File: rtl/tmc_nios2_rx_fifo_reader.sv
// tmc_nios2_rx_fifo_reader
// Converts each rising edge of the rx_fifo_read PIO level into one single-cycle
// RX FIFO read request, waits the FIFO read latency, captures the word and
// exposes it (plus status and a capture counter) on a small Avalon-MM slave.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   trig_in               PIO level; rising edge requests one pop
//   fifo_empty, fifo_q    RX FIFO empty flag and read data
//   fifo_rdreq            single-cycle FIFO read request (registered)
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write side
//   readdata              zero-wait combinational read mux
//   busy                  high while a pop is in flight (registered)
//
// Optional build macro TMC_RX_FIFO_READER_AUTOCLR_EN: when defined, reading
// address 0 (chipselect=1, write_n=1) clears valid on the next edge.
//
// Register map: 0 data, 1 status {fifo_empty,busy,overrun,underflow,valid},
//               2 W1C flags (bit0 valid, bit1 underflow, bit2 overrun), 3 cap_cnt.

module tmc_nios2_rx_fifo_reader #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trig_in,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              busy
);

    localparam int unsigned LAT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic              trig_d;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] data_reg;
    logic              valid;
    logic              underflow;
    logic              overrun;
    logic [CNT_W-1:0]  cap_cnt;

    logic rise;
    logic wr_en;
    logic clr_valid;
    logic clr_underflow;
    logic clr_overrun;
    logic clr_cnt;
    logic capture;
    logic wdata_unused;

    assign rise    = trig_in & ~trig_d;
    assign wr_en   = chipselect & ~write_n;
    assign capture = (state == S_WAIT) && (lat_cnt == LAT_W'(RD_LATENCY));

    // Software clear strobes; hardware sets below take priority over these
`ifdef TMC_RX_FIFO_READER_AUTOCLR_EN
    assign clr_valid = (wr_en && (address == 2'd2) && writedata[0]) ||
                       (chipselect && write_n && (address == 2'd0));
`else
    assign clr_valid = wr_en && (address == 2'd2) && writedata[0];
`endif
    assign clr_underflow = wr_en && (address == 2'd2) && writedata[1];
    assign clr_overrun   = wr_en && (address == 2'd2) && writedata[2];
    assign clr_cnt       = wr_en && (address == 2'd3);

    // Only the low three write-data bits carry meaning
    assign wdata_unused = ^writedata[31:3];

    // Pop sequencer, flags and counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            trig_d     <= 1'b1;  // a level already high at release is not an edge
            lat_cnt    <= '0;
            data_reg   <= '0;
            valid      <= 1'b0;
            underflow  <= 1'b0;
            overrun    <= 1'b0;
            cap_cnt    <= '0;
            fifo_rdreq <= 1'b0;
            busy       <= 1'b0;
        end else begin
            trig_d     <= trig_in;
            fifo_rdreq <= 1'b0;

            if (clr_valid)     valid     <= 1'b0;
            if (clr_underflow) underflow <= 1'b0;
            if (clr_overrun)   overrun   <= 1'b0;
            if (clr_cnt)       cap_cnt   <= '0;

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        if (fifo_empty) begin
                            underflow <= 1'b1;
                        end else begin
                            state      <= S_REQ;
                            fifo_rdreq <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (rise) overrun <= 1'b1;
                    lat_cnt <= LAT_W'(1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (rise) overrun <= 1'b1;
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (capture) begin
                        data_reg <= fifo_q;
                        valid    <= 1'b1;
                        if (valid) overrun <= 1'b1;
                        // a same-cycle counter clear still counts this capture
                        cap_cnt  <= clr_cnt ? CNT_W'(1) : cap_cnt + CNT_W'(1);
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-wait read mux, address decoded only
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(data_reg);
            2'd1:    readdata = {27'b0, fifo_empty, busy, overrun, underflow, valid};
            2'd2:    readdata = '0;
            default: readdata = 32'(cap_cnt);
        endcase
    end

endmodule

// File: tb/tb_tmc_nios2_rx_fifo_reader.sv
// Bench for tmc_nios2_rx_fifo_reader: instance a (RD_LATENCY=1, CNT_W=2, 32-bit
// data) and instance b (RD_LATENCY=3, 8-bit data), each fed by a FIFO model
// that drives real data only RD_LATENCY cycles after a read request.
module tb_tmc_nios2_rx_fifo_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic        a_trig = 1'b0, a_empty = 1'b0, a_rdreq, a_busy;
    logic [31:0] a_word = '0, a_q, a_wd = '0, a_rd;
    logic [1:0]  a_addr = '0;
    logic        a_cs = 1'b0, a_wn = 1'b1;
    // instance b
    logic        b_trig = 1'b0, b_empty = 1'b0, b_rdreq, b_busy;
    logic [7:0]  b_word = '0, b_p1, b_p2, b_q;
    logic [31:0] b_wd = '0, b_rd;
    logic [1:0]  b_addr = '0;
    logic        b_cs = 1'b0, b_wn = 1'b1;

    int errors = 0;
    int checks = 0;
    int a_rdreq_cnt = 0;
    int b_rdreq_cnt = 0;
    logic [31:0] exp_a[$];
    logic [7:0]  exp_b[$];

    tmc_nios2_rx_fifo_reader #(.DATA_W(32), .RD_LATENCY(1), .CNT_W(2)) u_a (
        .clk(clk), .reset_n(rst_n), .trig_in(a_trig), .fifo_empty(a_empty),
        .fifo_q(a_q), .fifo_rdreq(a_rdreq), .address(a_addr), .chipselect(a_cs),
        .write_n(a_wn), .writedata(a_wd), .readdata(a_rd), .busy(a_busy));

    tmc_nios2_rx_fifo_reader #(.DATA_W(8), .RD_LATENCY(3), .CNT_W(16)) u_b (
        .clk(clk), .reset_n(rst_n), .trig_in(b_trig), .fifo_empty(b_empty),
        .fifo_q(b_q), .fifo_rdreq(b_rdreq), .address(b_addr), .chipselect(b_cs),
        .write_n(b_wn), .writedata(b_wd), .readdata(b_rd), .busy(b_busy));

    // FIFO models: word valid exactly RD_LATENCY cycles after rdreq, junk otherwise
    always @(posedge clk) begin
        a_q  <= a_rdreq ? a_word : 32'hBAD0_BAD0;
        b_p1 <= b_rdreq ? b_word : 8'hEE;
        b_p2 <= b_p1;
        b_q  <= b_p2;
        if (a_rdreq) a_rdreq_cnt <= a_rdreq_cnt + 1;
        if (b_rdreq) b_rdreq_cnt <= b_rdreq_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [1:0] addr, input logic [31:0] d);
        a_cs = 1'b1; a_wn = 1'b0; a_addr = addr; a_wd = d;
        tick();
        a_cs = 1'b0; a_wn = 1'b1;
    endtask

    task automatic read_a(input logic [1:0] addr, output logic [31:0] v);
        a_addr = addr;
        #1;
        v = a_rd;
    endtask

    task automatic read_b(input logic [1:0] addr, output logic [31:0] v);
        b_addr = addr;
        #1;
        v = b_rd;
    endtask

    // Drive one rising edge on a and wait (bounded) for the pop to finish
    task automatic pop_a(input logic [31:0] w, output bit done);
        bit seen = 0;
        done = 0;
        a_word = w;
        exp_a.push_back(w);
        a_trig = 1'b0;
        tick();
        a_trig = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (a_busy) seen = 1;
            else if (seen) done = 1;
        end
        a_trig = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++; if (a_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b want 0", a_rdreq); end
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", a_busy, b_busy); end
        read_a(2'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", v); end
        read_a(2'd1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", v); end
        read_a(2'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", v); end
    endtask

    task automatic test_single_pop();
        logic [31:0] v;
        int rq0 = a_rdreq_cnt;
        a_word = 32'hA5A5_0001;
        exp_a.push_back(32'hA5A5_0001);
        a_trig = 1'b1;
        tick();
        checks++; if (a_rdreq !== 1'b1) begin errors++; $display("FAIL pop_rdreq_hi: got %b want 1", a_rdreq); end
        tick();
        checks++; if (a_rdreq !== 1'b0) begin errors++; $display("FAIL pop_rdreq_lo: got %b want 0", a_rdreq); end
        tick();
        read_a(2'd0, v);
        checks++; if (v !== exp_a[0]) begin errors++; $display("FAIL pop_data: got %h want %h", v, exp_a[0]); end
        void'(exp_a.pop_front());
        read_a(2'd1, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL pop_status: got %h want 1", v); end
        read_a(2'd3, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL pop_cnt: got %h want 1", v); end
        checks++; if (a_rdreq_cnt - rq0 !== 1) begin errors++; $display("FAIL pop_rdreq_count: got %0d want 1", a_rdreq_cnt - rq0); end
        a_trig = 1'b0;
        write_a(2'd1, 32'h7);
        read_a(2'd1, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL wr_addr1_noeffect: got %h want 1", v); end
        write_a(2'd2, 32'h1);
        read_a(2'd1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL clr_valid: got %h want 0", v); end
    endtask

    task automatic test_underflow();
        logic [31:0] v;
        int rq0 = a_rdreq_cnt;
        a_empty = 1'b1;
        a_trig = 1'b0;
        tick();
        a_trig = 1'b1;
        tick(); tick(); tick();
        checks++; if (a_rdreq_cnt != rq0) begin errors++; $display("FAIL uf_no_rdreq: got %0d pulses want 0", a_rdreq_cnt - rq0); end
        read_a(2'd1, v);
        checks++; if (v !== 32'h12) begin errors++; $display("FAIL uf_status: got %h want 12", v); end
        write_a(2'd2, 32'h2);
        read_a(2'd1, v);
        checks++; if (v !== 32'h10) begin errors++; $display("FAIL uf_clear: got %h want 10", v); end
        a_empty = 1'b0;
        a_trig = 1'b0;
        tick();
    endtask

    task automatic test_overrun_latency3();
        logic [31:0] v;
        int rq0 = b_rdreq_cnt;
        int busy_cyc = 0;
        int rdreq_i = -1;
        int valid_i = -1;
        b_addr = 2'd1;
        b_word = 8'h5C;
        exp_b.push_back(8'h5C);
        b_trig = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (b_busy) busy_cyc++;
            if (b_rdreq && rdreq_i < 0) rdreq_i = i;
            if (b_rd[0] && valid_i < 0) valid_i = i;
            if (i == 2) b_trig = 1'b0;
            if (i == 3) b_trig = 1'b1;  // second rise lands in WAIT
            if (i == 6) b_trig = 1'b0;
        end
        checks++; if (b_rdreq_cnt - rq0 != 1) begin errors++; $display("FAIL ov_rdreq_count: got %0d want 1", b_rdreq_cnt - rq0); end
        checks++; if (valid_i - rdreq_i != 4) begin errors++; $display("FAIL ov_capture_lat: got %0d want 4 (rdreq %0d valid %0d)", valid_i - rdreq_i, rdreq_i, valid_i); end
        checks++; if (busy_cyc != 4) begin errors++; $display("FAIL ov_busy_cycles: got %0d want 4", busy_cyc); end
        read_b(2'd1, v);
        checks++; if (v !== 32'h5) begin errors++; $display("FAIL ov_status: got %h want 5", v); end
        read_b(2'd0, v);
        checks++; if (v !== {24'h0, exp_b[0]}) begin errors++; $display("FAIL ov_data: got %h want %h", v, {24'h0, exp_b[0]}); end
        void'(exp_b.pop_front());
    endtask

    task automatic test_trig_high_reset();
        logic [31:0] v;
        bit done;
        int rq0;
        a_trig = 1'b1;
        do_reset();
        rq0 = a_rdreq_cnt;
        tick(); tick(); tick();
        checks++; if (a_rdreq_cnt != rq0 || a_busy !== 1'b0) begin errors++; $display("FAIL hi_release: got %0d pulses busy %b want 0 0", a_rdreq_cnt - rq0, a_busy); end
        pop_a(32'h1234_5678, done);
        checks++; if (!done || a_rdreq_cnt - rq0 != 1) begin errors++; $display("FAIL hi_then_pop: got done %0d pulses %0d want 1 1", done, a_rdreq_cnt - rq0); end
        read_a(2'd0, v);
        checks++; if (v !== exp_a[0]) begin errors++; $display("FAIL hi_pop_data: got %h want %h", v, exp_a[0]); end
        void'(exp_a.pop_front());
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int rq0 = a_rdreq_cnt;
        a_word = 32'hDEAD_0005;
        a_trig = 1'b0;
        tick();
        a_trig = 1'b1;
        tick();
        checks++; if (a_rdreq !== 1'b1) begin errors++; $display("FAIL mid_req: got %b want 1", a_rdreq); end
        rst_n = 1'b0;
        tick();
        checks++; if (a_rdreq !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_rdreq_low: got %b/%b want 0/0", a_rdreq, a_busy); end
        rst_n = 1'b1;
        tick(); tick(); tick();
        read_a(2'd1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_status: got %h want 0", v); end
        read_a(2'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_cnt: got %h want 0", v); end
        checks++; if (a_rdreq_cnt - rq0 != 1) begin errors++; $display("FAIL mid_pulses: got %0d want 1", a_rdreq_cnt - rq0); end
        a_trig = 1'b0;
        tick();
    endtask

    task automatic test_cnt_wrap();
        logic [31:0] v;
        bit done;
        for (int k = 0; k < 4; k++) begin
            pop_a(32'hC0DE_0000 + 32'(k), done);
            read_a(2'd0, v);
            checks++; if (!done || v !== exp_a[0]) begin errors++; $display("FAIL wrap_data%0d: got %h done %0d want %h", k, v, done, exp_a[0]); end
            void'(exp_a.pop_front());
        end
        read_a(2'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL wrap_cnt: got %h want 0", v); end
        read_a(2'd1, v);
        checks++; if (v !== 32'h5) begin errors++; $display("FAIL wrap_overrun: got %h want 5", v); end
        // capture edge coincides with the counter-clear write
        a_word = 32'h0BAD_F00D;
        exp_a.push_back(32'h0BAD_F00D);
        a_trig = 1'b0;
        tick();
        a_trig = 1'b1;
        tick(); tick();
        write_a(2'd3, 32'h0);
        a_trig = 1'b0;
        read_a(2'd3, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL clr_vs_capture: got %h want 1", v); end
        read_a(2'd0, v);
        checks++; if (v !== exp_a[0]) begin errors++; $display("FAIL clr_vs_capture_data: got %h want %h", v, exp_a[0]); end
        void'(exp_a.pop_front());
        write_a(2'd3, 32'hFFFF);
        read_a(2'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL cnt_clear: got %h want 0", v); end
    endtask

    initial begin
        test_reset();
        test_single_pop();
        test_underflow();
        test_overrun_latency3();
        test_trig_high_reset();
        test_reset_mid();
        test_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmc_nios2_rx_fifo_reader.md
Name: tmc_nios2_rx_fifo_reader

Overview:
Downstream consumer of the Nios II "rx_fifo_read" PIO output bit. Turns each rising edge of that PIO level into exactly one single-cycle read request to the RX data FIFO. Waits the FIFO's read latency, captures the FIFO word, and presents it to the CPU on a small Avalon-MM slave (data, status, control, capture count). Lets firmware pop the RX FIFO one word at a time without a direct FIFO-to-bus bridge.

Parameters:
DATA_W, 32, FIFO word width (1..32); readdata zero-extended above DATA_W.
RD_LATENCY, 1, cycles from fifo_rdreq to valid fifo_q (legal 1..3).
CNT_W, 16, width of capture counter (1..32).

Ports:
clk  in  1  system clock, all logic rising-edge.
reset_n  in  1  synchronous active-low reset.
trig_in  in  1  level from rx_fifo_read PIO out_port; rising edge requests one pop.
fifo_empty  in  1  RX FIFO empty flag.
fifo_q  in  DATA_W  RX FIFO read data, valid RD_LATENCY cycles after rdreq.
fifo_rdreq  out  1  single-cycle FIFO read request.
address  in  2  Avalon-MM slave word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data.
readdata  out  32  combinational read mux (zero-wait read).
busy  out  1  high while a pop is in flight (state != IDLE).

Behaviour:
- Clocking: one clock, clk. Reset: synchronous, active-low, on reset_n, sampled on clk rising edge.
- Reset values: fifo_rdreq=0, busy=0, data_reg=0, valid=0, underflow=0, overrun=0, cap_cnt=0, lat_cnt=0, state=IDLE, trig_d=1. trig_d resets to 1 so a trig_in already high at reset release is not an edge.
- Edge detect: trig_d<=trig_in every cycle; rise = trig_in & ~trig_d.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, rise & fifo_empty: set underflow sticky; stay IDLE; no rdreq.
  - IDLE, rise & ~fifo_empty: go to REQ.
  - REQ: fifo_rdreq=1 for exactly this one cycle; lat_cnt<=1; go to WAIT.
  - WAIT: lat_cnt increments each cycle. In the cycle where lat_cnt==RD_LATENCY: data_reg<=fifo_q, valid<=1, cap_cnt<=cap_cnt+1 (wraps 2^CNT_W-1 -> 0), then go to IDLE.
  - Timing: rdreq occurs 1 cycle after the rise is sampled. Capture completes RD_LATENCY cycles after rdreq. busy=1 in REQ and WAIT.
- rise while not IDLE: ignored (no second pop); overrun sticky set.
- Capture while valid already 1: data_reg overwritten; overrun set.
- Register map (read, address):
  - 0: data_reg zero-extended.
  - 1: status {27'b0, fifo_empty, busy, overrun, underflow, valid} (bit0=valid).
  - 2: reads 0.
  - 3: cap_cnt zero-extended.
- Writes (chipselect & ~write_n):
  - address 2, write-1-to-clear: bit0 clears valid, bit1 underflow, bit2 overrun.
  - address 3, any write: cap_cnt<=0.
  - Other addresses: no effect.
- Simultaneous events: hardware set beats software clear in the same cycle, for valid, underflow, overrun and cap_cnt. A capture plus a counter-clear write leaves cap_cnt=1.
- Reset mid-operation: in-flight pop abandoned. fifo_rdreq low from the first clk edge with reset_n=0. No capture.
- readdata is address-decoded only (chipselect not required), zero-wait.

Optional Feature:
TMC_RX_FIFO_READER_AUTOCLR_EN.
- Defined: any cycle with chipselect=1, write_n=1, address=0 (data read) clears valid on the next edge. A same-cycle capture still wins.
- Undefined: valid is cleared only by a write to address 2 bit0.

Test Plan:
1. Reset, FIFO holds 0xA5A5_0001, RD_LATENCY=1, toggle trig_in 0->1 -> rdreq high exactly 1 cycle, one cycle later addr0 reads 0xA5A5_0001, status=0x01, addr3=1.
2. fifo_empty=1, trig_in rise -> no rdreq, status bit1 (underflow)=1; write 0x2 to addr2 -> status bit1=0.
3. RD_LATENCY=3, rise, then second rise during WAIT -> single rdreq, capture 3 cycles after rdreq, overrun=1, busy high for exactly 4 cycles.
4. Hold trig_in=1 through reset release -> no rdreq. Then trig_in 0->1 -> one rdreq.
5. Assert reset_n=0 in the REQ cycle -> rdreq low next edge, valid=0, cap_cnt=0.
6. CNT_W=2, perform 4 pops -> addr3 reads 0. Write addr3 in the same cycle as a capture -> reads 1.
